// File: rtl/shift_reg_bank.sv
// shift_reg_bank: serial-in shift register with a fill-tracking FSM that
// latches complete frames into a static or dynamic holding register on the
// rising edge of the corresponding select input.
module shift_reg_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             sdi,
  input  logic             shift_en,
  input  logic             sel_stat,
  input  logic             sel_dyn,
  output logic             sdo,
  output logic [WIDTH-1:0] stat_reg,
  output logic [WIDTH-1:0] dyn_reg,
  output logic             stat_valid,
  output logic             dyn_valid,
  output logic             frame_err,
  output logic [1:0]       state
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'b00,
    S_FILLING = 2'b01,
    S_FULL    = 2'b10
  } fill_state_t;

  fill_state_t      state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] shreg_q;
  logic             sel_stat_q, sel_dyn_q;
  logic             stat_ev, dyn_ev, any_ev;
  logic             take_stat, take_dyn, reject;

  // Select edge detection and latch/reject decisions
  always_comb begin
    stat_ev   = sel_stat & ~sel_stat_q;
    dyn_ev    = sel_dyn  & ~sel_dyn_q;
    any_ev    = stat_ev | dyn_ev;
    take_stat = stat_ev & ~dyn_ev & (state_q == S_FULL);
    take_dyn  = dyn_ev & ~stat_ev & (state_q == S_FULL);
    reject    = any_ev & ~take_stat & ~take_dyn;
  end

  // Fill FSM state register and bit counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next counter and state: any select event restarts the frame; a
  // coincident shift bit becomes bit 1 of the new frame
  always_comb begin
    cnt_n   = cnt_q;
    state_n = state_q;
    if (any_ev) begin
      cnt_n = shift_en ? CW'(1) : '0;
    end else if (shift_en && (cnt_q != FULL_CNT)) begin
      cnt_n = cnt_q + CW'(1);
    end
    if (cnt_n == '0) begin
      state_n = S_EMPTY;
    end else if (cnt_n == FULL_CNT) begin
      state_n = S_FULL;
    end else begin
      state_n = S_FILLING;
    end
  end

  // Shift register, select history, holding registers and status flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg_q    <= '0;
      sel_stat_q <= 1'b0;
      sel_dyn_q  <= 1'b0;
      stat_reg   <= '0;
      dyn_reg    <= '0;
      stat_valid <= 1'b0;
      dyn_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sel_stat_q <= sel_stat;
      sel_dyn_q  <= sel_dyn;
      if (shift_en) begin
        shreg_q <= {shreg_q[WIDTH-2:0], sdi};
      end
      if (take_stat) begin
        stat_reg   <= shreg_q;
        stat_valid <= 1'b1;
      end
      if (take_dyn) begin
        dyn_reg   <= shreg_q;
        dyn_valid <= 1'b1;
      end
      frame_err <= reject;
    end
  end

  assign sdo   = shreg_q[WIDTH-1];
  assign state = state_q;

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench for shift_reg_bank with WIDTH=8.
module tb_shift_reg_bank;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       sdi = 1'b0;
  logic       shift_en = 1'b0;
  logic       sel_stat = 1'b0;
  logic       sel_dyn = 1'b0;
  logic       sdo;
  logic [7:0] stat_reg, dyn_reg;
  logic       stat_valid, dyn_valid, frame_err;
  logic [1:0] state;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  shift_reg_bank #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .sdi(sdi), .shift_en(shift_en),
    .sel_stat(sel_stat), .sel_dyn(sel_dyn), .sdo(sdo),
    .stat_reg(stat_reg), .dyn_reg(dyn_reg), .stat_valid(stat_valid),
    .dyn_valid(dyn_valid), .frame_err(frame_err), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      sdi = b[7-i];
      shift_en = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic d);
    sel_stat = s;
    sel_dyn = d;
    tick();
    sel_stat = 1'b0;
    sel_dyn = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_state", state, 0);
    check("rst_sdo", sdo, 0);
    check("rst_stat", stat_reg, 0);
    check("rst_dyn", dyn_reg, 0);
    check("rst_valid", {stat_valid, dyn_valid, frame_err}, 0);
    #10 RST_N = 1'b1;
    tick();

    // A5 into static
    shift_bits(8'hA5, 8);
    check("a5_full", state, 2'b10);
    check("a5_sdo", sdo, 1);
    pulse(1'b1, 1'b0);
    check("a5_stat", stat_reg, 8'hA5);
    check("a5_sv", stat_valid, 1);
    check("a5_state", state, 0);
    check("a5_ferr", frame_err, 0);

    // 3C into dynamic
    shift_bits(8'h3C, 8);
    pulse(1'b0, 1'b1);
    check("3c_dyn", dyn_reg, 8'h3C);
    check("3c_dv", dyn_valid, 1);
    check("3c_stat", stat_reg, 8'hA5);

    // Short frame rejected
    shift_bits(8'hB0, 5);
    check("short_fill", state, 2'b01);
    pulse(1'b1, 1'b0);
    check("short_ferr", frame_err, 1);
    check("short_stat", stat_reg, 8'hA5);
    check("short_sv", stat_valid, 1);
    check("short_state", state, 0);
    tick();
    check("short_ferr_end", frame_err, 0);

    // FF then 00: MSB stays 1 through the second byte, counter saturates
    shift_bits(8'hFF, 8);
    for (int unsigned i = 0; i < 8; i++) begin
      check("ff_sdo", sdo, 1);
      shift_bits(8'h00, 1);
      check("ff_full", state, 2'b10);
    end
    check("zero_sdo", sdo, 0);
    pulse(1'b0, 1'b1);
    check("zero_dyn", dyn_reg, 8'h00);

    // Simultaneous selects rejected
    shift_bits(8'hC3, 8);
    pulse(1'b1, 1'b1);
    check("both_ferr", frame_err, 1);
    check("both_stat", stat_reg, 8'hA5);
    check("both_dyn", dyn_reg, 8'h00);
    check("both_state", state, 0);

    // Held select produces one event only
    shift_bits(8'h69, 8);
    sel_stat = 1'b1;
    tick();
    check("hold_stat", stat_reg, 8'h69);
    check("hold_ferr0", frame_err, 0);
    tick();
    tick();
    check("hold_ferr1", frame_err, 0);
    check("hold_state", state, 0);
    sel_stat = 1'b0;
    tick();

    // Shift coincident with latch: pre-shift value latched, new bit is bit 1
    shift_bits(8'h81, 8);
    sel_stat = 1'b1;
    shift_en = 1'b1;
    sdi = 1'b1;
    tick();
    sel_stat = 1'b0;
    shift_en = 1'b0;
    sdi = 1'b0;
    check("co_stat", stat_reg, 8'h81);
    check("co_state", state, 2'b01);
    shift_bits(8'h00, 6);
    check("co_fill7", state, 2'b01);
    shift_bits(8'h00, 1);
    check("co_full8", state, 2'b10);
    pulse(1'b0, 1'b1);
    check("co_dyn", dyn_reg, 8'h80);

    // Asynchronous reset mid-frame
    shift_bits(8'hF0, 4);
    #2 RST_N = 1'b0;
    #1;
    check("arst_out", {stat_reg, dyn_reg, stat_valid, dyn_valid, frame_err, sdo, state}, 0);
    #5 RST_N = 1'b1;
    tick();
    check("arst_empty", state, 0);
    shift_bits(8'h5A, 8);
    pulse(1'b1, 1'b0);
    check("arst_stat", stat_reg, 8'h5A);

    // Select held across reset release gives an event on first clock
    @(negedge CLK);
    RST_N = 1'b0;
    sel_dyn = 1'b1;
    #3 RST_N = 1'b1;
    tick();
    check("relsel_ferr", frame_err, 1);
    sel_dyn = 1'b0;
    tick();
    check("relsel_end", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
